// File: rtl/usb_fs_bit_tx.sv
// usb_fs_bit_tx: full-speed USB bit transmitter (SYNC, stuffing, NRZI, EOP).
// Ports: clk_48mhz/reset; tx_data/tx_valid/tx_last in, tx_ready/underrun
// pulses out; usb_p_tx/usb_n_tx/usb_tx_en to the pads; busy = not IDLE.
module usb_fs_bit_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STUFF_LEN + 1);
  localparam int EW = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STUFF_MAX = SW'(STUFF_LEN);
  localparam logic [EW-1:0] EOP_MAX   = EW'(EOP_SE0_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [SW-1:0] stuff_cnt;
  logic [EW-1:0] eop_cnt;
  logic          last_q;
  logic          line_j;

  logic bit_strobe;
  logic in_bits;
  logic stuff_now;
  logic fetch;
  logic eop_go;
  logic send_bit;
  logic next_j;

  assign bit_strobe = (cnt == CNT_MAX);
  assign in_bits    = (state == SYNC) || (state == DATA);
  assign stuff_now  = (stuff_cnt == STUFF_MAX);

  // A byte boundary is only reached once any pending stuff bit is out.
  assign fetch    = in_bits && bit_strobe && !stuff_now &&
                    (bit_idx == 3'd7);
  assign tx_ready = fetch && !last_q && tx_valid;
  assign underrun = fetch && !last_q && !tx_valid;
  assign eop_go   = fetch && (last_q || !tx_valid);
  assign busy     = (state != IDLE);

  // shreg[0] is the bit currently on the line; shreg[1] is next.
  always_comb begin
    send_bit = 1'b0;
    if (stuff_now)
      send_bit = 1'b0;
    else if (fetch)
      send_bit = tx_data[0];
    else
      send_bit = shreg[1];
  end

  // NRZI: a 0 flips J/K, a 1 holds the line.
  assign next_j = send_bit ? line_j : ~line_j;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      stuff_cnt <= '0;
      eop_cnt   <= '0;
      last_q    <= 1'b0;
      line_j    <= 1'b1;
      usb_p_tx  <= 1'b1;
      usb_n_tx  <= 1'b0;
      usb_tx_en <= 1'b0;
    end else begin
      if (state != IDLE)
        cnt <= bit_strobe ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            // SYNC goes through the same shifter as data;
            // its first 0 is put on the line right away.
            state     <= SYNC;
            cnt       <= '0;
            shreg     <= 8'h80;
            bit_idx   <= '0;
            stuff_cnt <= '0;
            last_q    <= 1'b0;
            line_j    <= 1'b0;
            usb_p_tx  <= 1'b0;
            usb_n_tx  <= 1'b1;
            usb_tx_en <= 1'b1;
          end
        end
        SYNC, DATA: begin
          if (bit_strobe) begin
            if (eop_go) begin
              state    <= EOP_SE0;
              eop_cnt  <= '0;
              usb_p_tx <= 1'b0;
              usb_n_tx <= 1'b0;
            end else begin
              if (fetch) begin
                state   <= DATA;
                shreg   <= tx_data;
                bit_idx <= '0;
                last_q  <= tx_last;
              end else if (!stuff_now) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
              end
              stuff_cnt <= send_bit ? stuff_cnt + 1'b1 : '0;
              line_j    <= next_j;
              usb_p_tx  <= next_j;
              usb_n_tx  <= ~next_j;
            end
          end
        end
        EOP_SE0: begin
          if (bit_strobe) begin
            if (eop_cnt == EOP_MAX) begin
              state    <= EOP_J;
              usb_p_tx <= 1'b1;
              usb_n_tx <= 1'b0;
            end else begin
              eop_cnt <= eop_cnt + 1'b1;
            end
          end
        end
        EOP_J: begin
          if (bit_strobe) begin
            state     <= IDLE;
            line_j    <= 1'b1;
            usb_tx_en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_bit_tx.sv
// tb_usb_fs_bit_tx: vector table, hand sequences and random packets
// checked cycle by cycle against a bit-list model of the USB line.
module tb_usb_fs_bit_tx;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       usb_p_tx;
  logic       usb_n_tx;
  logic       usb_tx_en;
  logic       busy;
  logic       underrun;

  usb_fs_bit_tx dut (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .usb_p_tx  (usb_p_tx),
    .usb_n_tx  (usb_n_tx),
    .usb_tx_en (usb_tx_en),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int tests = 0;
  int fails = 0;

  logic [7:0] pb [8];
  int         pn;
  bit         pund;

  logic [1:0] exp_sym [$];
  int         exp_rdy [$];
  int         exp_und;

  int m_en, m_rdy_n, m_last_rdy, m_und;

  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          und;
    int          exp_bits;
    int          exp_rdy_n;
    int          exp_last_rdy;
    int          exp_und;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Line model: raw bits (SYNC + data LSB first), stuffing after six 1s,
  // NRZI from J, then SE0 SE0 J. Fetch/underrun cycles follow from the
  // line position of each byte boundary (4 clocks per bit).
  task automatic build_model();
    bit bits [$];
    int ones;
    bit lvl;
    bit x;
    ones = 0;
    exp_sym.delete();
    exp_rdy.delete();
    exp_und = -1;
    for (int j = 0; j < 8 * (pn + 1); j++) begin
      if (j >= 8 && j % 8 == 0)
        exp_rdy.push_back(4 * bits.size() - 1);
      if (j < 8) x = (j == 7);
      else       x = pb[j / 8 - 1][j % 8];
      bits.push_back(x);
      ones = x ? ones + 1 : 0;
      if (ones == 6) begin
        bits.push_back(1'b0);
        ones = 0;
      end
    end
    if (pund) exp_und = 4 * bits.size() - 1;
    lvl = 1'b1;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      exp_sym.push_back({lvl, ~lvl});
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  task automatic set_inputs(input int bi);
    tx_valid = (bi < pn);
    tx_data  = (bi < pn) ? pb[bi] : 8'h00;
    tx_last  = (bi == pn - 1) && !pund;
  endtask

  task automatic start_pkt();
    @(negedge clk_48mhz);
    set_inputs(0);
    @(posedge clk_48mhz);
  endtask

  task automatic run_packet(input string nm);
    int L, bi, mism, to;
    bit adv, rdy_e;
    logic [5:0] act, exp;
    logic [1:0] sym;
    string info;
    build_model();
    L = exp_sym.size();
    m_en = 0; m_rdy_n = 0; m_last_rdy = -1; m_und = -1;
    mism = 0; info = ""; bi = 0; adv = 0;
    start_pkt();
    for (int k = 0; k < 4 * L + 4; k++) begin
      @(negedge clk_48mhz);
      if (adv) begin
        bi++;
        set_inputs(bi);
        adv = 0;
      end
      rdy_e = 0;
      foreach (exp_rdy[i]) if (exp_rdy[i] == k) rdy_e = 1;
      sym = (k < 4 * L) ? exp_sym[k / 4] : 2'b10;
      exp = {k < 4 * L, k < 4 * L, sym, rdy_e, k == exp_und};
      act = {usb_tx_en, busy, usb_p_tx, usb_n_tx, tx_ready, underrun};
      if (act !== exp) begin
        if (mism == 0)
          info = $sformatf(" k=%0d en,busy,p,n,rdy,und=%b exp %b",
                           k, act, exp);
        mism++;
      end
      if (usb_tx_en) m_en++;
      if (tx_ready) begin
        m_rdy_n++;
        m_last_rdy = k;
        adv = 1;
      end
      if (underrun) m_und = k;
    end
    tx_valid = 1'b0;
    check({nm, " trace", info}, mism, 0);
    to = 0;
    while (busy && to < 300) begin
      @(negedge clk_48mhz);
      to++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s idle_timeout: busy=%0d, want 0", nm, busy);
    end
  endtask

  initial begin
    tbl[0] = '{1, 32'h00,       0, 19, 1, 31, -1};
    tbl[1] = '{1, 32'hFF,       0, 20, 1, 31, -1};
    tbl[2] = '{3, 32'h030201,   0, 35, 3, 95, -1};
    tbl[3] = '{1, 32'h55,       1, 19, 1, 31, 63};
    tbl[4] = '{2, 32'hFFFF,     0, 29, 2, 67, -1};
    tbl[5] = '{1, 32'hFC,       0, 20, 1, 31, -1};
    tbl[6] = '{2, 32'h00FC,     0, 28, 2, 67, -1};
    tbl[7] = '{1, 32'h3F,       0, 20, 1, 31, -1};

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check("rst en", usb_tx_en, 0);
    check("rst p", usb_p_tx, 1);
    check("rst n", usb_n_tx, 0);
    check("rst busy", busy, 0);
    check("rst ready", tx_ready, 0);
    check("rst underrun", underrun, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_48mhz);

    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      pn = tbl[v].n;
      pund = tbl[v].und;
      for (int b = 0; b < 4; b++) pb[b] = tbl[v].bytes[8*b +: 8];
      run_packet(nm);
      check({nm, " en_cycles"}, m_en, 4 * tbl[v].exp_bits);
      check({nm, " ready_cnt"}, m_rdy_n, tbl[v].exp_rdy_n);
      check({nm, " last_ready_k"}, m_last_rdy, tbl[v].exp_last_rdy);
      check({nm, " underrun_k"}, m_und, tbl[v].exp_und);
    end

    // Reset during the 4th data bit of a 0x00 packet.
    pn = 1; pund = 0; pb[0] = 8'h00;
    start_pkt();
    repeat (46) @(negedge clk_48mhz);
    check("mid en before rst", usb_tx_en, 1);
    reset = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk_48mhz);
    #1;
    check("mid rst en", usb_tx_en, 0);
    check("mid rst p", usb_p_tx, 1);
    check("mid rst n", usb_n_tx, 0);
    check("mid rst busy", busy, 0);
    @(negedge clk_48mhz);
    reset = 1'b0;
    pn = 1; pund = 0; pb[0] = 8'hA5;
    run_packet("after_rst");

    for (int r = 0; r < 30; r++) begin
      pn = $urandom_range(1, 4);
      pund = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 4; b++)
        pb[b] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk_48mhz);
      run_packet($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
